pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Parametrised hazard/forwarding controller for the 5-stage pipeline: scoreboard of in-flight writers.
// - Per ID-stage read port: registered forward select; load-use stall; IF/ID and ID/EX flush for jumps and taken branches.
// - Sits beside the ID/EX register. The pipeline top consumes its stall/flush/select outputs in place of the tied-off flush wires.
// PARAMETERS
// ADDR_W      5   register address width; address 0 is never a hazard
// N_RD        2   read ports checked in ID
// FWD_DEPTH   3   tracked stages after ID: sb[0]=EX, sb[1]=MEM, sb[2]=WB
// LOAD_READY  2   lowest sb index whose load data is forwardable (2 = WB); range 1..FWD_DEPTH-1
// CNT_W       16  width of the saturating stall/flush counters
// SEL_W = clog2(FWD_DEPTH+1), derived localparam
// PORTS
// clk           in   1              clock, rising edge
// reset         in   1              asynchronous, active-low reset
// id_valid      in   1              ID holds a real instruction
// id_regwr      in   1              ID instruction writes a register
// id_memread    in   1              ID instruction is a load
// id_waddr      in   ADDR_W         ID destination register
// id_raddr      in   N_RD*ADDR_W    ID source registers, port p at [p*ADDR_W +: ADDR_W]
// id_ruse       in   N_RD           source port p actually read
// id_jump       in   1              jump resolved in ID
// ex_br_taken   in   1              branch resolved taken in EX
// stall         out  1              hold PC and IF/ID; insert bubble into ID/EX
// flush_if_id   out  1              clear IF/ID next edge
// flush_id_ex   out  1              clear ID/EX next edge
// fwd_sel       out  N_RD*SEL_W     registered, valid with the instruction in EX: 0 = regfile, k = result of sb[k]
// stall_cnt     out  CNT_W          saturating count of stall cycles
// flush_cnt     out  CNT_W          saturating count of cycles with ex_br_taken or an issued id_jump
// BEHAVIOUR
// - Reset (async, reset=0): all sb entries invalid; fwd_sel=0; stall_cnt=flush_cnt=0. stall and flush_* are combinational and evaluate to 0 with the scoreboard empty and inputs low.
// - Entry: {v, wr, ld, waddr}. A match requires v & wr & waddr!=0 & waddr==src & id_ruse[p].
// - Scoreboard shifts every edge. sb[i+1]<=sb[i]; last entry drops.
// - sb[0] loads the ID entry when it issues, i.e. id_valid & !stall & !ex_br_taken. Otherwise sb[0] loads a bubble (v=0).
// - Lookahead: ID consumer matching sb[i] sees the producer at sb[i+1] when it reaches EX.
// - stall = id_valid & !ex_br_taken & exists p, i: match(sb[i]) & sb[i].ld & (i+1 < LOAD_READY).
// - The ID instruction itself matches as a virtual sb[-1], so a load directly ahead stalls LOAD_READY-1 cycles (1 by default).
// - fwd_sel[p] <= youngest match index i+1 with i+1 < FWD_DEPTH, else 0.
// - Matches at i+1 >= FWD_DEPTH read the regfile, which writes before it reads.
// - fwd_sel updates only on issue. It is cleared to 0 on a bubble, a stall or a flush.
// - Youngest match wins: the lowest index beats older writers of the same register.
// - Flush: ex_br_taken drives flush_if_id=1 and flush_id_ex=1. The wrong-path ID instruction does not enter sb.
// - Flush: id_jump & id_valid & !stall & !ex_br_taken drives flush_if_id=1 only.
// - Priority: ex_br_taken over stall over jump. A stalled jump waits; its flush occurs on its issue cycle.
// - Counters: +1 per qualifying cycle, hold at all-ones (no wrap).
// - Reset asserted mid-stall or mid-flush: state cleared immediately. No stall persists after release.
// - No combinational path from fwd_sel to stall. Stall depends only on ID inputs and sb.
// STRUCTURE
// - Shared header pipeline_defs.vh:
//   - FWD_REGFILE=0 encoding.
//   - Scoreboard entry field offsets/width.
//   - Default stage indices EX/MEM/WB.
// - One sub-module, hazard_match: combinational compare of one source port against all sb entries.
//   - Returns {hit, youngest index, load_block}.
//   - Instantiated N_RD times via generate.
// - Top holds the sb shift register, fwd_sel registers, flush/stall logic and counters.
// TESTING
// 1. Reset low 3 cycles, then release with idle inputs -> all outputs 0, counters 0 for 10 cycles.
// 2. add $8 then sub uses $8 on port0 next cycle -> fwd_sel[0]=1 in EX cycle; stall=0.
//    Same consumer two later -> 2; three later -> 0 (regfile).
// 3. lw $9 then add uses $9 on port1 -> stall=1 exactly one cycle, stall_cnt=1, then fwd_sel[1]=2.
//    With LOAD_READY=3 -> two stall cycles.
// 4. Writes to $0 from a preceding lw and add, consumer reads $0 -> no stall, fwd_sel=0.
//    Two writers of $5 at sb[0] and sb[1] -> consumer gets fwd_sel=1.
// 5. ex_br_taken=1 with a load-use stall pending -> stall=0, flush_if_id=flush_id_ex=1, flush_cnt=1.
//    Next cycle sb[0].v=0.
// 6. id_jump while stalled on load -> flush_if_id only on the issue cycle.
//    Then assert reset mid-sequence -> sb cleared and fwd_sel=0 asynchronously.
//    Force 2^CNT_W stalls -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Holds the forward-select encoding, the default stage indices and the
// scoreboard entry flag layout.
package pipe_hazard_ctrl_pkg;

    // Forward select value meaning "read the register file"
    localparam int unsigned FWD_REGFILE = 0;

    // Scoreboard index of each stage after ID
    localparam int unsigned STAGE_EX  = 0;
    localparam int unsigned STAGE_MEM = 1;
    localparam int unsigned STAGE_WB  = 2;

    // Per-entry control flags; the destination address is kept alongside
    typedef struct packed {
        logic v;   // entry holds a real instruction
        logic wr;  // instruction writes a register
        logic ld;  // instruction is a load
    } sb_flags_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Combinational compare of one ID source port against every scoreboard entry.
// Ports:
//   src, ruse          source register and its "actually read" qualifier
//   sb_flags, sb_waddr scoreboard contents, entry i address at [i*ADDR_W +: ADDR_W]
//   hit_c              some in-flight writer matches
//   idx_c              youngest match position as seen from EX (i+1)
//   load_block_c       a matching load is too young to forward
module pipe_hazard_ctrl_hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FWD_DEPTH  = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [ADDR_W-1:0]           src,
    input  logic                        ruse,
    input  sb_flags_t [FWD_DEPTH-1:0]   sb_flags,
    input  logic [FWD_DEPTH*ADDR_W-1:0] sb_waddr,
    output logic                        hit_c,
    output logic [SEL_W-1:0]            idx_c,
    output logic                        load_block_c
);

    // Scan youngest to oldest; the first hit fixes the forward position
    always_comb begin
        logic m;
        m            = 1'b0;
        hit_c        = 1'b0;
        idx_c        = '0;
        load_block_c = 1'b0;
        for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
            m = ruse && sb_flags[i].v && sb_flags[i].wr
                && (sb_waddr[i*ADDR_W +: ADDR_W] != '0)
                && (sb_waddr[i*ADDR_W +: ADDR_W] == src);
            if (m && !hit_c) begin
                hit_c = 1'b1;
                idx_c = SEL_W'(i + 1);
            end
            // Consumer would reach EX with the load at i+1, before its data exists
            if (m && sb_flags[i].ld && (i + 1 < LOAD_READY)) begin
                load_block_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// Tracks in-flight writers in a shift-register scoreboard (sb[0]=EX ...),
// produces load-use stall, IF/ID and ID/EX flushes, registered per-port
// forward selects and saturating stall/flush cycle counters.
// Ports:
//   clk, reset                     clock, async active-low reset
//   id_valid/regwr/memread/waddr   ID instruction description
//   id_raddr, id_ruse              ID source registers and read enables
//   id_jump, ex_br_taken           control-flow redirects
//   stall, flush_if_id, flush_id_ex  combinational pipeline controls
//   fwd_sel                        registered, per port: 0 = regfile, k = sb[k]
//   stall_cnt, flush_cnt           saturating event counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter  int unsigned ADDR_W     = 5,
    parameter  int unsigned N_RD       = 2,
    parameter  int unsigned FWD_DEPTH  = STAGE_WB + 1,
    parameter  int unsigned LOAD_READY = STAGE_WB,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic                     id_regwr,
    input  logic                     id_memread,
    input  logic [ADDR_W-1:0]        id_waddr,
    input  logic [N_RD*ADDR_W-1:0]   id_raddr,
    input  logic [N_RD-1:0]          id_ruse,
    input  logic                     id_jump,
    input  logic                     ex_br_taken,
    output logic                     stall,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic [N_RD*SEL_W-1:0]    fwd_sel,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    sb_flags_t [FWD_DEPTH-1:0]   sb_flags;
    logic [FWD_DEPTH*ADDR_W-1:0] sb_waddr;
    logic [N_RD-1:0]             hit;
    logic [N_RD-1:0]             load_block;
    logic [N_RD*SEL_W-1:0]       idx;
    logic [N_RD*SEL_W-1:0]       fwd_next;
    logic                        issue;

    // One comparator per read port
    for (genvar p = 0; p < int'(N_RD); p++) begin : g_port
        pipe_hazard_ctrl_hazard_match #(
            .ADDR_W    (ADDR_W),
            .FWD_DEPTH (FWD_DEPTH),
            .LOAD_READY(LOAD_READY),
            .SEL_W     (SEL_W)
        ) u_match (
            .src         (id_raddr[p*ADDR_W +: ADDR_W]),
            .ruse        (id_ruse[p]),
            .sb_flags    (sb_flags),
            .sb_waddr    (sb_waddr),
            .hit_c       (hit[p]),
            .idx_c       (idx[p*SEL_W +: SEL_W]),
            .load_block_c(load_block[p])
        );
    end

    // Taken branch beats stall, stall beats jump
    assign stall       = id_valid && !ex_br_taken && (|load_block);
    assign issue       = id_valid && !stall && !ex_br_taken;
    assign flush_id_ex = ex_br_taken;
    assign flush_if_id = ex_br_taken || (id_jump && issue);

    // Forward only from positions the bypass network covers; older writers
    // have reached the regfile, which writes before it reads
    always_comb begin
        fwd_next = '0;
        for (int unsigned p = 0; p < N_RD; p++) begin
            if (issue && hit[p] && (32'(idx[p*SEL_W +: SEL_W]) < FWD_DEPTH)) begin
                fwd_next[p*SEL_W +: SEL_W] = idx[p*SEL_W +: SEL_W];
            end else begin
                fwd_next[p*SEL_W +: SEL_W] = SEL_W'(FWD_REGFILE);
            end
        end
    end

    // Scoreboard shift; a non-issuing cycle enters as a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_flags <= '0;
            sb_waddr <= '0;
        end else begin
            sb_flags[0]            <= issue ? {1'b1, id_regwr, id_memread} : '0;
            sb_waddr[ADDR_W-1:0]   <= issue ? id_waddr : '0;
            for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
                sb_flags[i]                   <= sb_flags[i-1];
                sb_waddr[i*ADDR_W +: ADDR_W]  <= sb_waddr[(i-1)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Forward selects follow the instruction into EX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_sel <= '0;
        end else begin
            fwd_sel <= fwd_next;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for single-cycle
// behaviour plus hand sequences for longer load latency, async reset and
// counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid, id_regwr, id_memread, id_jump, ex_br_taken;
    logic [4:0] id_waddr, ra0, ra1;
    logic [1:0] id_ruse;

    logic       stall, flush_if_id, flush_id_ex;
    logic [3:0] fwd_sel;
    logic [5:0] stall_cnt, flush_cnt;

    logic       stall3, fii3, fie3;
    logic [3:0] fwd_sel3;
    logic [5:0] stall_cnt3, flush_cnt3;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_regwr(id_regwr), .id_memread(id_memread),
        .id_waddr(id_waddr), .id_raddr({ra1, ra0}), .id_ruse(id_ruse),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(6), .LOAD_READY(3)) dut3 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_regwr(id_regwr), .id_memread(id_memread),
        .id_waddr(id_waddr), .id_raddr({ra1, ra0}), .id_ruse(id_ruse),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken),
        .stall(stall3), .flush_if_id(fii3), .flush_id_ex(fie3),
        .fwd_sel(fwd_sel3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v, wr, ld;
        logic [4:0] wa, r0, r1;
        logic [1:0] ru;
        logic       jmp, br;
        logic       e_stall, e_fii, e_fie;
        logic [1:0] e_s0, e_s1;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    function automatic vec_t mk(input int v, wr, ld, wa, r0, r1, ru, jmp, br,
                                input int es, efi, efe, s0, s1);
        vec_t r;
        r.v = 1'(v); r.wr = 1'(wr); r.ld = 1'(ld);
        r.wa = 5'(wa); r.r0 = 5'(r0); r.r1 = 5'(r1); r.ru = 2'(ru);
        r.jmp = 1'(jmp); r.br = 1'(br);
        r.e_stall = 1'(es); r.e_fii = 1'(efi); r.e_fie = 1'(efe);
        r.e_s0 = 2'(s0); r.e_s1 = 2'(s1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int v, wr, ld, wa, r0, r1, ru, jmp, br);
        id_valid = 1'(v); id_regwr = 1'(wr); id_memread = 1'(ld);
        id_waddr = 5'(wa); ra0 = 5'(r0); ra1 = 5'(r1); id_ruse = 2'(ru);
        id_jump = 1'(jmp); ex_br_taken = 1'(br);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // cols: v wr ld wa r0 r1 ru jmp br | stall fii fie sel0 sel1
        tbl[0]  = mk(1,1,0, 8,0,0, 0, 0,0,  0,0,0, 0,0);  // add $8
        tbl[1]  = mk(1,0,0, 0,8,0, 1, 0,0,  0,0,0, 0,0);  // use $8, distance 1
        tbl[2]  = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 1,0);
        tbl[3]  = mk(1,1,0, 8,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[4]  = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[5]  = mk(1,0,0, 0,8,0, 1, 0,0,  0,0,0, 0,0);  // distance 2
        tbl[6]  = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 2,0);
        tbl[7]  = mk(1,1,0, 8,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[8]  = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[9]  = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[10] = mk(1,0,0, 0,8,0, 1, 0,0,  0,0,0, 0,0);  // distance 3 -> regfile
        tbl[11] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[12] = mk(1,1,1, 9,0,0, 0, 0,0,  0,0,0, 0,0);  // lw $9
        tbl[13] = mk(1,0,0, 0,0,9, 2, 0,0,  1,0,0, 0,0);  // load-use on port1
        tbl[14] = mk(1,0,0, 0,0,9, 2, 0,0,  0,0,0, 0,0);
        tbl[15] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,2);
        tbl[16] = mk(1,1,1, 0,0,0, 0, 0,0,  0,0,0, 0,0);  // lw $0
        tbl[17] = mk(1,1,0, 0,0,0, 1, 0,0,  0,0,0, 0,0);  // add $0 reads $0
        tbl[18] = mk(1,0,0, 0,0,0, 3, 0,0,  0,0,0, 0,0);
        tbl[19] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[20] = mk(1,1,0, 5,0,0, 0, 0,0,  0,0,0, 0,0);  // two writers of $5
        tbl[21] = mk(1,1,0, 5,0,0, 0, 0,0,  0,0,0, 0,0);
        tbl[22] = mk(1,0,0, 0,5,5, 3, 0,0,  0,0,0, 0,0);
        tbl[23] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 1,1);
        tbl[24] = mk(1,1,1, 9,0,0, 0, 0,0,  0,0,0, 0,0);  // lw $9
        tbl[25] = mk(1,1,0,12,9,0, 1, 0,1,  0,1,1, 0,0);  // branch beats stall
        tbl[26] = mk(1,0,0, 0,9,12,3, 0,0,  0,0,0, 0,0);  // $12 writer never entered
        tbl[27] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 2,0);
        tbl[28] = mk(1,1,1, 9,0,0, 0, 0,0,  0,0,0, 0,0);  // lw $9
        tbl[29] = mk(1,0,0, 0,9,0, 1, 1,0,  1,0,0, 0,0);  // jr $9 stalled
        tbl[30] = mk(1,0,0, 0,9,0, 1, 1,0,  0,1,0, 0,0);  // jump issues
        tbl[31] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 2,0);
        tbl[32] = mk(0,0,0, 0,0,0, 0, 0,0,  0,0,0, 0,0);

        // Reset and idle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        step();
        chk("rst_fwd_sel", 32'(fwd_sel), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #2;
            chk($sformatf("idle%0d_stall", c), 32'(stall), 0);
            chk($sformatf("idle%0d_flush", c), 32'({flush_if_id, flush_id_ex}), 0);
            chk($sformatf("idle%0d_fwd_sel", c), 32'(fwd_sel), 0);
            chk($sformatf("idle%0d_cnts", c), 32'({stall_cnt, flush_cnt}), 0);
            step();
        end

        // Vector table
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].v, tbl[k].wr, tbl[k].ld, tbl[k].wa, tbl[k].r0, tbl[k].r1,
                  tbl[k].ru, tbl[k].jmp, tbl[k].br);
            #2;
            chk($sformatf("r%0d_stall", k), 32'(stall), 32'(tbl[k].e_stall));
            chk($sformatf("r%0d_flush_if_id", k), 32'(flush_if_id), 32'(tbl[k].e_fii));
            chk($sformatf("r%0d_flush_id_ex", k), 32'(flush_id_ex), 32'(tbl[k].e_fie));
            chk($sformatf("r%0d_sel0", k), 32'(fwd_sel[1:0]), 32'(tbl[k].e_s0));
            chk($sformatf("r%0d_sel1", k), 32'(fwd_sel[3:2]), 32'(tbl[k].e_s1));
            step();
        end
        chk("tbl_stall_cnt", 32'(stall_cnt), 2);
        chk("tbl_flush_cnt", 32'(flush_cnt), 2);

        // LOAD_READY=3: load-use stalls two cycles, then reads the regfile
        do_reset();
        drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 9, 2, 0, 0);
        #2;
        chk("lr3_c1_stall", 32'(stall3), 1);
        chk("lr2_c1_stall", 32'(stall), 1);
        step();
        #2;
        chk("lr3_c2_stall", 32'(stall3), 1);
        chk("lr2_c2_stall", 32'(stall), 0);
        step();
        #2;
        chk("lr3_c3_stall", 32'(stall3), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("lr3_fwd_sel", 32'(fwd_sel3), 0);
        chk("lr3_stall_cnt", 32'(stall_cnt3), 2);
        step();

        // Async reset while stalled with a live forward select
        do_reset();
        drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 9, 8, 0, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0);
        #2;
        chk("pre_rst_stall", 32'(stall), 1);
        chk("pre_rst_sel0", 32'(fwd_sel[1:0]), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 0);
        chk("async_rst_fwd_sel", 32'(fwd_sel), 0);
        step();
        chk("held_rst_fwd_sel", 32'(fwd_sel), 0);
        chk("held_rst_stall_cnt", 32'(stall_cnt), 0);
        reset = 1'b1;
        #2;
        chk("post_rst_stall", 32'(stall), 0);
        step();
        #2;
        chk("post_rst_stall2", 32'(stall), 0);
        chk("post_rst_stall_cnt", 32'(stall_cnt), 0);
        step();

        // Stall counter saturation: a self-dependent load stalls every other cycle
        do_reset();
        drive(1, 1, 1, 9, 9, 0, 1, 0, 0);
        repeat (20) step();
        chk("sat_partial", 32'(stall_cnt), 10);
        repeat (120) step();
        chk("sat_full", 32'(stall_cnt), 63);
        repeat (4) step();
        chk("sat_hold", 32'(stall_cnt), 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
